// File: rtl/avalon_csr_pkg.sv
// avalon_csr_pkg: register map, default version and access-type lookup for avalon_csr_bank.
package avalon_csr_pkg;
    localparam int unsigned A_NUMPKTS   = 0;
    localparam int unsigned A_START     = 1;
    localparam int unsigned A_STOP      = 2;
    localparam int unsigned A_PKTLENGTH = 3;
    localparam int unsigned A_PAYLOAD   = 4;
    localparam int unsigned A_VERSION   = 5;
    localparam int unsigned A_SCRATCH   = 6;
    localparam int unsigned A_PKT_COUNT = 7;
    localparam logic [63:0] VERSION_DEFAULT = 64'h12;
    typedef enum logic [1:0] {RW, RO, CMD} access_t;
    function automatic access_t access_of(input logic [31:0] a);
        return (a == A_START || a == A_STOP) ? CMD :
               (a == A_VERSION || a == A_PKT_COUNT) ? RO : RW;
    endfunction
endpackage

// File: rtl/avalon_csr_bank_if.sv
// avalon_csr_bank_if: Avalon-MM slave bus signals with master/slave views.
interface avalon_csr_bank_if #(parameter int DATA_W = 32, parameter int ADDR_W = 3);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    modport master(output address, read, write, writedata, byteenable, input readdata, readdatavalid);
    modport slave(input address, read, write, writedata, byteenable, output readdata, readdatavalid);
endinterface

// File: rtl/avalon_rd_pipe.sv
// avalon_rd_pipe: LAT-stage valid/data shift register for the fixed-latency read path.
module avalon_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic              vld_q [LAT];
    logic [DATA_W-1:0] dat_q [LAT];
    for (genvar s = 0; s < LAT; s++) begin : g_stage
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                vld_q[s] <= 1'b0;
                dat_q[s] <= '0;
            end else begin
                vld_q[s] <= (s == 0) ? valid_i : vld_q[(s == 0) ? 0 : s-1];
                dat_q[s] <= (s == 0) ? data_i  : dat_q[(s == 0) ? 0 : s-1];
            end
    end
    assign valid_o = vld_q[LAT-1];
    assign data_o  = dat_q[LAT-1];
endmodule

// File: rtl/avalon_csr_bank.sv
// avalon_csr_bank: Avalon-MM register bank for the packet generator with byte-enabled
// writes, command pulses, a saturating packet counter and a pipelined read path.
module avalon_csr_bank
    import avalon_csr_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = $clog2(NUM_REGS),
    parameter int READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] VERSION = DATA_W'(VERSION_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    avalon_csr_bank_if.slave  bus,
    input  logic              pkt_done,
    output logic [DATA_W-1:0] cfg_numpkts,
    output logic [DATA_W-1:0] cfg_pktlength,
    output logic [DATA_W-1:0] cfg_payload,
    output logic              start_pulse,
    output logic              stop_pulse
);
    localparam int BE_W = DATA_W/8;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] count_q, count_d, rdata, rd_dat;
    logic [31:0]       addr;
    logic              start_q, stop_q, start_cmd, stop_cmd, cmd, rd_req, rd_vld;
    access_t           acc;
    assign addr      = 32'(bus.address);
    assign acc       = access_of(addr);
    assign cmd       = bus.write && acc == CMD && bus.byteenable[0] && bus.writedata[0];
    assign start_cmd = cmd && addr == A_START;
    assign stop_cmd  = cmd && addr == A_STOP;
    // A simultaneous write wins over the read, so the read never enters the pipe.
    assign rd_req    = bus.read && !bus.write;
    assign rdata     = addr == A_VERSION   ? VERSION :
                       addr == A_PKT_COUNT ? count_q :
                       acc == RW           ? regs_q[bus.address] : '0;
    assign count_d   = start_cmd ? '0 : (pkt_done && !(&count_q)) ? count_q + 1'b1 : count_q;
    always_comb begin
        regs_d = regs_q;
        for (int b = 0; b < BE_W; b++)
            if (bus.write && acc == RW && bus.byteenable[b])
                regs_d[bus.address][8*b +: 8] = bus.writedata[8*b +: 8];
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            regs_q  <= '{default: '0};
            count_q <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
            start_q <= start_cmd;
            stop_q  <= stop_cmd;
        end
    avalon_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (rd_req),
        .data_i  (rd_req ? rdata : '0),
        .valid_o (rd_vld),
        .data_o  (rd_dat)
    );
    assign bus.readdatavalid = rd_vld;
    assign bus.readdata      = rd_dat;
    assign cfg_numpkts       = regs_q[A_NUMPKTS];
    assign cfg_pktlength     = regs_q[A_PKTLENGTH];
    assign cfg_payload       = regs_q[A_PAYLOAD];
    assign start_pulse       = start_q;
    assign stop_pulse        = stop_q;
endmodule

// File: tb/tb_avalon_csr_bank.sv
// tb_avalon_csr_bank: directed vector table plus reset-in-flight sequence for avalon_csr_bank
// with DATA_W=32 and READ_LATENCY=2.
module tb_avalon_csr_bank;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pkt_done;
    logic [31:0] cfg_numpkts, cfg_pktlength, cfg_payload;
    logic        start_pulse, stop_pulse;
    int          checks = 0;
    int          failures = 0;

    avalon_csr_bank_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    avalon_csr_bank #(.DATA_W(32), .NUM_REGS(8), .READ_LATENCY(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .pkt_done      (pkt_done),
        .cfg_numpkts   (cfg_numpkts),
        .cfg_pktlength (cfg_pktlength),
        .cfg_payload   (cfg_payload),
        .start_pulse   (start_pulse),
        .stop_pulse    (stop_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        pkt;
        logic        ev;
        logic [31:0] ed;
        logic        es;
        logic        ep;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic pkt, input logic ev, input logic [31:0] ed,
                       input logic es, input logic ep);
        vecs.push_back('{wr, rd, a, wd, be, pkt, ev, ed, es, ep});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic pkt);
        bus.write = wr; bus.read = rd; bus.address = a;
        bus.writedata = wd; bus.byteenable = be; pkt_done = pkt;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        // Each row: inputs applied at this negedge; expectations are outputs seen just before.
        add(0,1,0,0,0,0, 0,0,0,0);
        add(0,1,1,0,0,0, 0,0,0,0);
        add(0,1,2,0,0,0, 1,0,0,0);
        add(0,1,3,0,0,0, 1,0,0,0);
        add(0,1,4,0,0,0, 1,0,0,0);
        add(0,1,5,0,0,0, 1,0,0,0);
        add(0,1,6,0,0,0, 1,0,0,0);
        add(0,1,7,0,0,0, 1,32'h12,0,0);
        add(1,0,3,32'hAABBCCDD,4'b0101,0, 1,0,0,0);
        add(0,1,3,0,0,0, 1,0,0,0);
        add(0,0,0,0,0,0, 0,0,0,0);
        add(1,0,1,1,4'b0001,0, 1,32'h00BB00DD,0,0);
        add(0,0,0,0,0,1, 0,0,1,0);
        add(0,0,0,0,0,1, 0,0,0,0);
        add(0,0,0,0,0,1, 0,0,0,0);
        add(0,1,7,0,0,0, 0,0,0,0);
        add(0,0,0,0,0,0, 0,0,0,0);
        add(1,0,1,1,4'b0001,1, 1,3,0,0);
        add(0,1,7,0,0,0, 0,0,1,0);
        add(1,0,5,32'hFF,4'hF,0, 0,0,0,0);
        add(1,0,7,5,4'hF,0, 1,0,0,0);
        add(0,1,5,0,0,0, 0,0,0,0);
        add(0,1,7,0,0,0, 0,0,0,0);
        add(1,0,1,2,4'b0001,0, 1,32'h12,0,0);
        add(0,1,1,0,0,0, 1,0,0,0);
        add(0,0,0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0,0, 1,0,0,0);
        add(1,0,2,1,4'b0001,0, 0,0,0,0);
        add(1,0,2,1,4'b0000,0, 0,0,0,1);
        add(0,0,0,0,0,0, 0,0,0,0);
        add(1,1,6,32'h1234,4'hF,0, 0,0,0,0);
        add(0,1,6,0,0,0, 0,0,0,0);
        add(0,0,0,0,0,0, 0,0,0,0);
        add(0,0,0,0,0,0, 1,32'h1234,0,0);
        add(0,0,0,0,0,0, 0,0,0,0);

        repeat (3) @(negedge clk);
        chk("reset_rdv", {31'b0, bus.readdatavalid}, 0);
        chk("reset_rdata", bus.readdata, 0);
        chk("reset_numpkts", cfg_numpkts, 0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_rdv", i), {31'b0, bus.readdatavalid}, {31'b0, vecs[i].ev});
            chk($sformatf("v%0d_rdata", i), bus.readdata, vecs[i].ed);
            chk($sformatf("v%0d_start", i), {31'b0, start_pulse}, {31'b0, vecs[i].es});
            chk($sformatf("v%0d_stop", i), {31'b0, stop_pulse}, {31'b0, vecs[i].ep});
            drive(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].wd, vecs[i].be, vecs[i].pkt);
        end

        @(negedge clk);
        chk("cfg_pktlength", cfg_pktlength, 32'h00BB00DD);
        drive(1, 0, 0, 32'h7, 4'hF, 0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0);
        chk("cfg_numpkts", cfg_numpkts, 32'h7);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        chk("inflight_rdv", {31'b0, bus.readdatavalid}, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_rdv", {31'b0, bus.readdatavalid}, 0);
        chk("async_rst_numpkts", cfg_numpkts, 0);
        chk("async_rst_pktlength", cfg_pktlength, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("flushed_rdv%0d", i), {31'b0, bus.readdatavalid}, 0);
        end
        drive(0, 1, 3, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_rdv", {31'b0, bus.readdatavalid}, 1);
        chk("post_rst_pktlength", bus.readdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/avalon_csr_bank.md
# avalon_csr_bank

Parametrised Avalon-MM slave register bank: the next generation of the packet-generator control registers, generalised in data width, register count and read latency. Adds byte enables, a pipelined fixed-latency read path with `readdatavalid`, self-clearing START/STOP command pulses, and a hardware-updated packet counter. Sits between the Avalon-MM interconnect and the packet generator core, driving its configuration and command inputs.

## Interface
- `DATA_W`, 32: data width; multiple of 8, from 8 to 64.
- `NUM_REGS`, 8: register count; at least 8, power of two.
- `ADDR_W`, `$clog2(NUM_REGS)`: word address width.
- `READ_LATENCY`, 1: cycles from read request to `readdatavalid`; from 1 to 4.
- `VERSION`, `'h12`: reset and constant value of the VERSION register.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in ADDR_W: word address.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in DATA_W: write data.
- `byteenable` in DATA_W/8: byte lanes used on write.
- `readdata` out DATA_W: read data.
- `readdatavalid` out 1: `readdata` is valid this cycle.
- `pkt_done` in 1: one-cycle strobe from the core, one per packet sent.
- `cfg_numpkts`, `cfg_pktlength`, `cfg_payload` out DATA_W each: register contents.
- `start_pulse`, `stop_pulse` out 1: one-cycle command strobes.

## Operation
Register map (word address, access):
- 0 NUMPKTS: RW.
- 1 START: write-1 command; reads 0.
- 2 STOP: write-1 command; reads 0.
- 3 PKTLENGTH: RW.
- 4 PAYLOAD: RW.
- 5 VERSION: RO, constant `VERSION`.
- 6 SCRATCH: RW.
- 7 PKT_COUNT: RO.
- 8 to NUM_REGS-1: generic RW scratch.

Write behaviour:
- RW registers update only the byte lanes whose `byteenable` bit is set.
- Writes to RO addresses are dropped silently.
- START/STOP fire only when `byteenable[0]`=1 and `writedata[0]`=1; any other write to them is ignored.

PKT_COUNT:
- Increments by 1 on each `pkt_done`.
- Saturates at all-ones.
- Clears to 0 on a START command.

Simultaneous events:
- START command and `pkt_done` in the same cycle: the clear wins, count becomes 0.
- `read` and `write` in the same cycle (an illegal master): the write is performed, the read is dropped, and no `readdatavalid` is generated.

Reads:
- Register contents are sampled at the request edge.
- Result is returned through a READ_LATENCY-stage valid/data pipeline.
- No `waitrequest`; the slave accepts one read per cycle, fully pipelined.

## Timing
Reset values (`reset_n` low, asynchronous):
- All RW registers and PKT_COUNT are 0.
- `readdata` = 0, `readdatavalid` = 0.
- `start_pulse` = 0, `stop_pulse` = 0.

Writes:
- A write accepted at edge N is visible on the `cfg_*` outputs and to reads issued from edge N+1.
- `start_pulse`/`stop_pulse` are high for exactly the cycle after the accepting edge.
- Back-to-back command writes produce back-to-back pulses.

Reads:
- A read at edge N gives `readdatavalid`=1 with its data in the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1 that is the next cycle.
- A read issued in the cycle after a write returns the new value.
- A read of PKT_COUNT returns its value before any same-edge `pkt_done`.
- `readdata` is 0 whenever `readdatavalid` is 0.

Reset asserted mid-operation:
- The read pipeline is flushed and in-flight reads are lost.
- Pending pulses are cancelled.
- Operation resumes on the first edge after `reset_n` rises.

## Structure
Shared package `avalon_csr_pkg` holds:
- the register address constants (the map above);
- the default `VERSION`;
- access-type enum `{RW, RO, CMD}`;
- the function returning the access type for an address.

One sub-module, `avalon_rd_pipe`: a parametrised READ_LATENCY-stage valid/data shift register with asynchronous active-low reset.

## Test plan
All scenarios use DATA_W=32 and READ_LATENCY=2.
- Reset, then read addresses 0 to 7 back-to-back → `readdatavalid` for 8 consecutive cycles; data 0,0,0,0,0,`'h12`,0,0.
- Write PKTLENGTH=`'hAABBCCDD` with `byteenable`=`4'b0101`, then read → `'h00BB00DD`.
- Write START=1, then 3 `pkt_done` strobes → one `start_pulse` cycle; PKT_COUNT reads 3. Write START again together with `pkt_done` → PKT_COUNT reads 0.
- Write VERSION=`'hFF` and PKT_COUNT=5 → both unchanged (`'h12` and the current count).
- Assert `reset_n` low between a read request and its `readdatavalid` → no `readdatavalid` appears; registers return to reset values.
- Write START with `writedata`=2 → no `start_pulse`; reading START returns 0.
